// File: rtl/lsb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsb_queue_pkg
// Description : Shared constants, FSM state encoding and helper functions
//               for the in-order load/store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package lsb_queue_pkg;

    localparam int XLEN = 32;

    // Memory access size codes (loads; stores reuse the low two bits)
    localparam logic [2:0] FUNC3_B  = 3'b000;
    localparam logic [2:0] FUNC3_H  = 3'b001;
    localparam logic [2:0] FUNC3_W  = 3'b010;
    localparam logic [2:0] FUNC3_BU = 3'b100;
    localparam logic [2:0] FUNC3_HU = 3'b101;

    // Byte-length encodings presented to the memory controller
    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_2 = 3'd2;
    localparam logic [2:0] LEN_4 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } lsb_state_e;

    function automatic logic [2:0] func3_to_len(input logic [2:0] f3);
        logic [2:0] len;
        case (f3[1:0])
            2'b00:   len = LEN_1;
            2'b01:   len = LEN_2;
            default: len = LEN_4;
        endcase
        return len;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                    input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] res;
        case (f3)
            FUNC3_B:  res = {{24{raw[7]}}, raw[7:0]};
            FUNC3_BU: res = {24'h0, raw[7:0]};
            FUNC3_H:  res = {{16{raw[15]}}, raw[15:0]};
            FUNC3_HU: res = {16'h0, raw[15:0]};
            FUNC3_W:  res = raw;
            default:  res = raw;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : lsb_queue_if
// Description : Bundle of every non-clock/reset signal of the load/store
//               buffer: global control, dispatch, CDB snoop, ROB commit,
//               memory-controller handshake and load writeback.
//               master : the surrounding core (dispatch, ROB, CDB, MemCtrl)
//               slave  : the load/store buffer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface lsb_queue_if #(
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) ();
    import lsb_queue_pkg::*;

    logic                      rdy;
    logic                      rollback;

    logic                      disp_valid;
    logic                      disp_is_store;
    logic [2:0]                disp_func3;
    logic                      disp_rs1_rdy;
    logic                      disp_rs2_rdy;
    logic [XLEN-1:0]           disp_rs1_val;
    logic [XLEN-1:0]           disp_rs2_val;
    logic [ROB_W-1:0]          disp_rs1_tag;
    logic [ROB_W-1:0]          disp_rs2_tag;
    logic [XLEN-1:0]           disp_imm;
    logic [ROB_W-1:0]          disp_rob_id;
    logic                      full;

    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*ROB_W-1:0]  cdb_tag;
    logic [NUM_CDB*XLEN-1:0]   cdb_data;

    logic                      commit_valid;
    logic [ROB_W-1:0]          commit_rob_id;
    logic [ROB_W-1:0]          rob_head_id;

    logic                      mem_req_valid;
    logic                      mem_req_store;
    logic [XLEN-1:0]           mem_req_addr;
    logic [2:0]                mem_req_len;
    logic [XLEN-1:0]           mem_req_data;
    logic                      mem_resp_valid;
    logic [XLEN-1:0]           mem_resp_data;

    logic                      out_valid;
    logic [ROB_W-1:0]          out_rob_id;
    logic [XLEN-1:0]           out_data;

    modport master (
        output rdy, rollback,
        output disp_valid, disp_is_store, disp_func3, disp_rs1_rdy, disp_rs2_rdy,
        output disp_rs1_val, disp_rs2_val, disp_rs1_tag, disp_rs2_tag, disp_imm, disp_rob_id,
        input  full,
        output cdb_valid, cdb_tag, cdb_data,
        output commit_valid, commit_rob_id, rob_head_id,
        input  mem_req_valid, mem_req_store, mem_req_addr, mem_req_len, mem_req_data,
        output mem_resp_valid, mem_resp_data,
        input  out_valid, out_rob_id, out_data
    );

    modport slave (
        input  rdy, rollback,
        input  disp_valid, disp_is_store, disp_func3, disp_rs1_rdy, disp_rs2_rdy,
        input  disp_rs1_val, disp_rs2_val, disp_rs1_tag, disp_rs2_tag, disp_imm, disp_rob_id,
        output full,
        input  cdb_valid, cdb_tag, cdb_data,
        input  commit_valid, commit_rob_id, rob_head_id,
        output mem_req_valid, mem_req_store, mem_req_addr, mem_req_len, mem_req_data,
        input  mem_resp_valid, mem_resp_data,
        output out_valid, out_rob_id, out_data
    );

endinterface
`default_nettype wire

// File: rtl/lsb_cdb_snoop.sv
`default_nettype none
// ============================================================================
// Module      : lsb_cdb_snoop
// Description : Combinational NUM_CDB-way tag match against the result
//               buses. The lowest-numbered matching channel wins.
// Ports       : cdb_valid/cdb_tag/cdb_data - packed result buses
//               tag  - producer tag being waited on
//               hit  - some valid channel carries tag
//               data - value from the winning channel (0 when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_cdb_snoop
    import lsb_queue_pkg::*;
#(
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  wire logic [NUM_CDB-1:0]       cdb_valid,
    input  wire logic [NUM_CDB*ROB_W-1:0] cdb_tag,
    input  wire logic [NUM_CDB*XLEN-1:0]  cdb_data,
    input  wire logic [ROB_W-1:0]         tag,
    output logic                          hit,
    output logic [XLEN-1:0]               data
);

    // Scan from the top so the lowest-index match overwrites last.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_tag[c*ROB_W +: ROB_W] == tag)) begin
                hit  = 1'b1;
                data = cdb_data[c*XLEN +: XLEN];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsb_queue.sv
`default_nettype none
// ============================================================================
// Module      : lsb_queue
// Description : In-order load/store buffer between dispatch, the ROB and the
//               memory controller. Entries wait for operands from the CDB,
//               issue one at a time from the head; stores only after commit.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - lsb_queue_if.slave (control, dispatch, CDB, commit,
//                       memory handshake, load writeback)
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_queue
    import lsb_queue_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter int         ROB_W   = 4,
    parameter int         NUM_CDB = 2,
    parameter logic [1:0] IO_HI   = 2'b11
) (
    input wire logic   clk,
    input wire logic   rst_n,
    lsb_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lsb_state_e       state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, cmt_cnt_q, cmt_cnt_d;

    logic             valid_q [DEPTH], valid_d [DEPTH];
    logic             store_q [DEPTH], store_d [DEPTH];
    logic             cmtd_q  [DEPTH], cmtd_d  [DEPTH];
    logic [2:0]       func3_q [DEPTH], func3_d [DEPTH];
    logic             rs1_rdy_q [DEPTH], rs1_rdy_d [DEPTH];
    logic             rs2_rdy_q [DEPTH], rs2_rdy_d [DEPTH];
    logic [XLEN-1:0]  rs1_val_q [DEPTH], rs1_val_d [DEPTH];
    logic [XLEN-1:0]  rs2_val_q [DEPTH], rs2_val_d [DEPTH];
    logic [ROB_W-1:0] rs1_tag_q [DEPTH], rs1_tag_d [DEPTH];
    logic [ROB_W-1:0] rs2_tag_q [DEPTH], rs2_tag_d [DEPTH];
    logic [XLEN-1:0]  imm_q   [DEPTH], imm_d   [DEPTH];
    logic [ROB_W-1:0] rob_q   [DEPTH], rob_d   [DEPTH];

    logic             req_valid_q, req_valid_d, req_store_q, req_store_d;
    logic [XLEN-1:0]  req_addr_q, req_addr_d, req_data_q, req_data_d;
    logic [2:0]       req_len_q, req_len_d;
    logic             out_valid_q, out_valid_d;
    logic [ROB_W-1:0] out_rob_q, out_rob_d;
    logic [XLEN-1:0]  out_data_q, out_data_d;

    // ---------------------------------------------------------------- snoop
    logic [DEPTH-1:0] w_rs1_hit, w_rs2_hit;
    logic [XLEN-1:0]  w_rs1_data [DEPTH];
    logic [XLEN-1:0]  w_rs2_data [DEPTH];
    logic             w_d1_hit, w_d2_hit;
    logic [XLEN-1:0]  w_d1_data, w_d2_data;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        lsb_cdb_snoop #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_rs1 (
            .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
            .tag(rs1_tag_q[gi]), .hit(w_rs1_hit[gi]), .data(w_rs1_data[gi]));
        lsb_cdb_snoop #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_rs2 (
            .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
            .tag(rs2_tag_q[gi]), .hit(w_rs2_hit[gi]), .data(w_rs2_data[gi]));
    end

    // Dispatch-side bypass: a result broadcast in the dispatch cycle itself.
    lsb_cdb_snoop #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_disp_rs1 (
        .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
        .tag(bus.disp_rs1_tag), .hit(w_d1_hit), .data(w_d1_data));
    lsb_cdb_snoop #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_disp_rs2 (
        .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
        .tag(bus.disp_rs2_tag), .hit(w_d2_hit), .data(w_d2_data));

    // ----------------------------------------------------------- head view
    logic [XLEN-1:0] w_head_addr;
    logic            w_head_store, w_issue, w_retire, w_disp_take;

    assign w_head_addr  = rs1_val_q[head_q] + imm_q[head_q];
    assign w_head_store = store_q[head_q];
    // MMIO loads have side effects, so they wait until nothing older can roll back.
    assign w_issue = (state_q == ST_IDLE) && (count_q != '0) && valid_q[head_q]
                   && rs1_rdy_q[head_q] && rs2_rdy_q[head_q]
                   && (w_head_store ? cmtd_q[head_q]
                                    : (!bus.rollback && ((w_head_addr[17:16] != IO_HI)
                                       || (rob_q[head_q] == bus.rob_head_id))));
    assign w_retire    = bus.rdy && (state_q != ST_IDLE) && bus.mem_resp_valid;
    // A slot freed by a retiring head is immediately reusable by dispatch.
    assign bus.full    = (count_q == CNT_W'(DEPTH)) && !w_retire;
    assign w_disp_take = bus.rdy && bus.disp_valid && !bus.full && !bus.rollback;

    // ----------------------------------------------------------- next state
    always_comb begin
        logic cmt_inc;
        logic keep_head;
        cmt_inc   = 1'b0;
        keep_head = 1'b0;
        state_d = state_q;   head_d = head_q;   tail_d = tail_q;
        count_d = count_q;   cmt_cnt_d = cmt_cnt_q;
        req_valid_d = req_valid_q; req_store_d = req_store_q; req_addr_d = req_addr_q;
        req_data_d  = req_data_q;  req_len_d   = req_len_q;
        out_valid_d = out_valid_q; out_rob_d   = out_rob_q;   out_data_d = out_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i];     store_d[i] = store_q[i];   cmtd_d[i] = cmtd_q[i];
            func3_d[i] = func3_q[i];     imm_d[i]   = imm_q[i];     rob_d[i]  = rob_q[i];
            rs1_rdy_d[i] = rs1_rdy_q[i]; rs1_val_d[i] = rs1_val_q[i]; rs1_tag_d[i] = rs1_tag_q[i];
            rs2_rdy_d[i] = rs2_rdy_q[i]; rs2_val_d[i] = rs2_val_q[i]; rs2_tag_d[i] = rs2_tag_q[i];
        end

        if (bus.rdy) begin
            out_valid_d = 1'b0;

            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && !rs1_rdy_q[i] && w_rs1_hit[i]) begin
                    rs1_rdy_d[i] = 1'b1;
                    rs1_val_d[i] = w_rs1_data[i];
                end
                if (valid_q[i] && !rs2_rdy_q[i] && w_rs2_hit[i]) begin
                    rs2_rdy_d[i] = 1'b1;
                    rs2_val_d[i] = w_rs2_data[i];
                end
                if (bus.commit_valid && valid_q[i] && store_q[i] && !cmtd_q[i]
                    && (rob_q[i] == bus.commit_rob_id)) begin
                    cmtd_d[i] = 1'b1;
                    cmt_inc   = 1'b1;
                end
            end
            cmt_cnt_d = cmt_cnt_q + CNT_W'(cmt_inc);

            case (state_q)
                ST_IDLE: begin
                    if (w_issue) begin
                        req_valid_d = 1'b1;
                        req_store_d = w_head_store;
                        req_addr_d  = w_head_addr;
                        req_len_d   = func3_to_len(func3_q[head_q]);
                        req_data_d  = rs2_val_q[head_q];
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT, ST_DRAIN: begin
                    if (bus.mem_resp_valid) begin
                        req_valid_d     = 1'b0;
                        valid_d[head_q] = 1'b0;
                        head_d          = head_q + PTR_W'(1);
                        count_d         = count_q - CNT_W'(1);
                        if (w_head_store) begin
                            cmt_cnt_d = cmt_cnt_d - CNT_W'(1);
                        end
                        if ((state_q == ST_WAIT) && !w_head_store) begin
                            out_valid_d = 1'b1;
                            out_rob_d   = rob_q[head_q];
                            out_data_d  = load_extend(func3_q[head_q], bus.mem_resp_data);
                        end
                        state_d = ST_IDLE;
                    end else if ((state_q == ST_WAIT) && bus.rollback && !w_head_store) begin
                        state_d = ST_DRAIN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (w_disp_take) begin
                valid_d[tail_q]   = 1'b1;
                store_d[tail_q]   = bus.disp_is_store;
                cmtd_d[tail_q]    = 1'b0;
                func3_d[tail_q]   = bus.disp_func3;
                imm_d[tail_q]     = bus.disp_imm;
                rob_d[tail_q]     = bus.disp_rob_id;
                rs1_rdy_d[tail_q] = bus.disp_rs1_rdy | w_d1_hit;
                rs1_val_d[tail_q] = bus.disp_rs1_rdy ? bus.disp_rs1_val : w_d1_data;
                rs1_tag_d[tail_q] = bus.disp_rs1_tag;
                rs2_rdy_d[tail_q] = bus.disp_rs2_rdy | w_d2_hit;
                rs2_val_d[tail_q] = bus.disp_rs2_rdy ? bus.disp_rs2_val : w_d2_data;
                rs2_tag_d[tail_q] = bus.disp_rs2_tag;
                tail_d            = tail_q + PTR_W'(1);
                count_d           = count_d + CNT_W'(1);
            end

            if (bus.rollback) begin
                // An in-flight load that is not retiring this cycle stays at the
                // head until its response drains; committed stores sit behind it.
                keep_head = (state_q != ST_IDLE) && !w_head_store && !bus.mem_resp_valid;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!cmtd_d[i] && !(keep_head && (PTR_W'(i) == head_q))) begin
                        valid_d[i] = 1'b0;
                    end
                end
                tail_d      = head_d + PTR_W'(cmt_cnt_d) + PTR_W'(keep_head);
                count_d     = cmt_cnt_d + CNT_W'(keep_head);
                out_valid_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE; head_q <= '0; tail_q <= '0; count_q <= '0; cmt_cnt_q <= '0;
            req_valid_q <= 1'b0; req_store_q <= 1'b0; req_addr_q <= '0;
            req_data_q  <= '0;   req_len_q   <= '0;
            out_valid_q <= 1'b0; out_rob_q   <= '0;   out_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0; store_q[i] <= 1'b0; cmtd_q[i] <= 1'b0;
                func3_q[i] <= '0;   imm_q[i]   <= '0;   rob_q[i]  <= '0;
                rs1_rdy_q[i] <= 1'b0; rs1_val_q[i] <= '0; rs1_tag_q[i] <= '0;
                rs2_rdy_q[i] <= 1'b0; rs2_val_q[i] <= '0; rs2_tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d; head_q <= head_d; tail_q <= tail_d;
            count_q <= count_d; cmt_cnt_q <= cmt_cnt_d;
            req_valid_q <= req_valid_d; req_store_q <= req_store_d; req_addr_q <= req_addr_d;
            req_data_q  <= req_data_d;  req_len_q   <= req_len_d;
            out_valid_q <= out_valid_d; out_rob_q   <= out_rob_d;   out_data_q <= out_data_d;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i]; store_q[i] <= store_d[i]; cmtd_q[i] <= cmtd_d[i];
                func3_q[i] <= func3_d[i]; imm_q[i]   <= imm_d[i];   rob_q[i]  <= rob_d[i];
                rs1_rdy_q[i] <= rs1_rdy_d[i]; rs1_val_q[i] <= rs1_val_d[i]; rs1_tag_q[i] <= rs1_tag_d[i];
                rs2_rdy_q[i] <= rs2_rdy_d[i]; rs2_val_q[i] <= rs2_val_d[i]; rs2_tag_q[i] <= rs2_tag_d[i];
            end
        end
    end

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_store = req_store_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_len   = req_len_q;
    assign bus.mem_req_data  = req_data_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_rob_id    = out_rob_q;
    assign bus.out_data      = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lsb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsb_queue
// Description : Directed self-checking bench for lsb_queue with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsb_queue;
    import lsb_queue_pkg::*;

    localparam int DEPTH   = 16;
    localparam int ROB_W   = 4;
    localparam int NUM_CDB = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsb_queue_if #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) bus ();

    lsb_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB), .IO_HI(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rdy = 1'b1;          bus.rollback = 1'b0;
        bus.disp_valid = 1'b0;   bus.disp_is_store = 1'b0; bus.disp_func3 = FUNC3_W;
        bus.disp_rs1_rdy = 1'b1; bus.disp_rs2_rdy = 1'b1;
        bus.disp_rs1_val = '0;   bus.disp_rs2_val = '0;
        bus.disp_rs1_tag = '0;   bus.disp_rs2_tag = '0;
        bus.disp_imm = '0;       bus.disp_rob_id = '0;
        bus.cdb_valid = '0;      bus.cdb_tag = '0;         bus.cdb_data = '0;
        bus.commit_valid = 1'b0; bus.commit_rob_id = '0;   bus.rob_head_id = '0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    endtask

    // One-cycle dispatch; rs2 is always supplied ready.
    task automatic disp(input logic st, input logic [2:0] f3, input logic r1,
                        input logic [31:0] v1, input logic [3:0] t1,
                        input logic [31:0] v2, input logic [31:0] imm, input logic [3:0] rob);
        bus.disp_valid = 1'b1;  bus.disp_is_store = st; bus.disp_func3 = f3;
        bus.disp_rs1_rdy = r1;  bus.disp_rs1_val = v1;  bus.disp_rs1_tag = t1;
        bus.disp_rs2_rdy = 1'b1; bus.disp_rs2_val = v2; bus.disp_imm = imm;
        bus.disp_rob_id = rob;
        step();
        bus.disp_valid = 1'b0;
    endtask

    task automatic expect_req(input string tag, input int bound);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (bus.mem_req_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check_val({tag, "_req_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic respond(input logic [31:0] data);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        step();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] rob);
        bus.commit_valid  = 1'b1;
        bus.commit_rob_id = rob;
        step();
        bus.commit_valid  = 1'b0;
    endtask

    // Full load round trip with the writeback checked against exp.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] resp,
                           input logic [31:0] exp, input logic [3:0] rob);
        disp(1'b0, f3, 1'b1, 32'h0000_0400, 4'd0, 32'd0, 32'd0, rob);
        expect_req(tag, 4);
        check_val({tag, "_len"}, 32'(bus.mem_req_len), 32'(func3_to_len(f3)));
        respond(resp);
        check_val({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check_val({tag, "_out_data"}, bus.out_data, exp);
        check_val({tag, "_out_rob"}, 32'(bus.out_rob_id), 32'(rob));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    initial begin
        int n_req;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_full", 32'(bus.full), 32'd0);
        check_val("reset_req", 32'(bus.mem_req_valid), 32'd0);
        check_val("reset_out", 32'(bus.out_valid), 32'd0);
        check_val("reset_count", 32'(dut.count_q), 32'd0);
        rst_n = 1'b1;
        step();

        // ---- LW round trip
        disp(1'b0, FUNC3_W, 1'b1, 32'h100, 4'd0, 32'd0, 32'd4, 4'd1);
        expect_req("lw", 4);
        check_val("lw_addr", bus.mem_req_addr, 32'h104);
        check_val("lw_len", 32'(bus.mem_req_len), 32'd4);
        check_val("lw_store", 32'(bus.mem_req_store), 32'd0);
        respond(32'hDEAD_BEEF);
        check_val("lw_out_valid", 32'(bus.out_valid), 32'd1);
        check_val("lw_out_data", bus.out_data, 32'hDEAD_BEEF);
        check_val("lw_req_drop", 32'(bus.mem_req_valid), 32'd0);
        step();
        check_val("lw_out_pulse", 32'(bus.out_valid), 32'd0);

        // ---- extension variants
        do_load("lb",  FUNC3_B,  32'h0000_0080, 32'hFFFF_FF80, 4'd2);
        do_load("lbu", FUNC3_BU, 32'h1234_5680, 32'h0000_0080, 4'd3);
        do_load("lh",  FUNC3_H,  32'hABCD_8001, 32'hFFFF_8001, 4'd4);
        do_load("lhu", FUNC3_HU, 32'hFFFF_8001, 32'h0000_8001, 4'd5);

        // ---- store waits for commit
        disp(1'b1, FUNC3_W, 1'b1, 32'h300, 4'd0, 32'hCAFE_F00D, 32'd8, 4'd5);
        n_req = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.mem_req_valid) n_req++;
            step();
        end
        check_val("sw_hold", 32'(n_req), 32'd0);
        commit(4'd5);
        check_val("sw_commit_edge", 32'(bus.mem_req_valid), 32'd0);
        step();
        check_val("sw_req_next", 32'(bus.mem_req_valid), 32'd1);
        check_val("sw_store", 32'(bus.mem_req_store), 32'd1);
        check_val("sw_addr", bus.mem_req_addr, 32'h308);
        check_val("sw_data", bus.mem_req_data, 32'hCAFE_F00D);
        respond(32'h0);
        check_val("sw_no_out", 32'(bus.out_valid), 32'd0);

        // ---- fill to DEPTH, retire+dispatch same cycle
        disp(1'b0, FUNC3_W, 1'b1, 32'h500, 4'd0, 32'd0, 32'd0, 4'd0);
        for (int k = 1; k < DEPTH; k++) begin
            disp(1'b0, FUNC3_W, 1'b0, 32'd0, 4'd9, 32'd0, 32'd0, 4'(k));
        end
        check_val("fill_full", 32'(bus.full), 32'd1);
        check_val("fill_req", 32'(bus.mem_req_valid), 32'd1);
        disp(1'b0, FUNC3_W, 1'b0, 32'd0, 4'd9, 32'd0, 32'd0, 4'd1);
        check_val("full_disp_ignored", 32'(dut.count_q), 32'(DEPTH));
        bus.disp_valid = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = 32'h1;
        #1;
        check_val("full_drops_on_retire", 32'(bus.full), 32'd0);
        step();
        bus.disp_valid = 1'b0;
        bus.mem_resp_valid = 1'b0;
        check_val("retire_disp_full", 32'(bus.full), 32'd1);
        check_val("retire_disp_count", 32'(dut.count_q), 32'(DEPTH));
        bus.rollback = 1'b1;
        step();
        bus.rollback = 1'b0;
        check_val("flush_count", 32'(dut.count_q), 32'd0);

        // ---- CDB capture (ch0 other tag, ch1 matching tag)
        disp(1'b0, FUNC3_W, 1'b0, 32'd0, 4'd3, 32'd0, 32'h10, 4'd6);
        repeat (3) step();
        check_val("cdb_wait", 32'(bus.mem_req_valid), 32'd0);
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {4'd3, 4'd7};
        bus.cdb_data  = {32'h0000_0200, 32'h0000_0999};
        step();
        bus.cdb_valid = 2'b00;
        expect_req("cdb", 3);
        check_val("cdb_addr", bus.mem_req_addr, 32'h210);
        respond(32'h0);

        // ---- dispatch-cycle bypass, lowest channel wins
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {4'd4, 4'd4};
        bus.cdb_data  = {32'h0000_0500, 32'h0000_0400};
        disp(1'b0, FUNC3_W, 1'b0, 32'd0, 4'd4, 32'd0, 32'd0, 4'd7);
        bus.cdb_valid = 2'b00;
        expect_req("bypass", 3);
        check_val("bypass_addr", bus.mem_req_addr, 32'h400);
        respond(32'h0);

        // ---- rollback with load in flight
        disp(1'b0, FUNC3_W, 1'b1, 32'h1000, 4'd0, 32'd0, 32'd0, 4'd1);
        disp(1'b1, FUNC3_W, 1'b1, 32'h2000, 4'd0, 32'h11, 32'd0, 4'd2);
        disp(1'b1, FUNC3_W, 1'b1, 32'h2004, 4'd0, 32'h22, 32'd0, 4'd3);
        disp(1'b1, FUNC3_W, 1'b1, 32'h3000, 4'd0, 32'h33, 32'd0, 4'd4);
        disp(1'b0, FUNC3_W, 1'b1, 32'h3004, 4'd0, 32'd0, 32'd0, 4'd5);
        disp(1'b1, FUNC3_W, 1'b1, 32'h3008, 4'd0, 32'h66, 32'd0, 4'd6);
        commit(4'd2);
        commit(4'd3);
        bus.rollback = 1'b1;
        step();
        bus.rollback = 1'b0;
        check_val("drain_req_kept", 32'(bus.mem_req_valid), 32'd1);
        check_val("drain_addr", bus.mem_req_addr, 32'h1000);
        respond(32'h5555_5555);
        check_val("drain_no_out", 32'(bus.out_valid), 32'd0);
        check_val("drain_count", 32'(dut.count_q), 32'd2);
        expect_req("rb_sw0", 4);
        check_val("rb_sw0_addr", bus.mem_req_addr, 32'h2000);
        check_val("rb_sw0_data", bus.mem_req_data, 32'h11);
        respond(32'h0);
        expect_req("rb_sw1", 4);
        check_val("rb_sw1_addr", bus.mem_req_addr, 32'h2004);
        check_val("rb_sw1_data", bus.mem_req_data, 32'h22);
        respond(32'h0);
        n_req = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.mem_req_valid) n_req++;
            step();
        end
        check_val("rb_no_more_req", 32'(n_req), 32'd0);

        // ---- MMIO load gated on ROB head
        bus.rob_head_id = 4'd2;
        disp(1'b0, FUNC3_W, 1'b1, 32'h0003_0000, 4'd0, 32'd0, 32'd0, 4'd7);
        repeat (5) step();
        check_val("mmio_held", 32'(bus.mem_req_valid), 32'd0);
        bus.rob_head_id = 4'd7;
        step();
        check_val("mmio_issue", 32'(bus.mem_req_valid), 32'd1);
        check_val("mmio_addr", bus.mem_req_addr, 32'h0003_0000);
        // rdy=0 freezes the FSM even if a response pulse arrives
        bus.rdy = 1'b0;
        respond(32'h0000_00EE);
        check_val("frozen_req", 32'(bus.mem_req_valid), 32'd1);
        check_val("frozen_out", 32'(bus.out_valid), 32'd0);
        bus.rdy = 1'b1;
        respond(32'h0000_00AB);
        check_val("mmio_out_data", bus.out_data, 32'h0000_00AB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
